// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner for a packed 32-bit hex word.
// New words are staged and committed to the displayed shadow only at a frame wrap.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           data_in,
  input  logic                  data_load,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  update_pending,
  output logic                  frame_done
);

  localparam int unsigned           CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned           IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0]       CntMax = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0]       IdxMax = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SegOff = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DigOff = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [CntW-1:0]       r_div_cnt;
  logic [IdxW-1:0]       r_idx;
  logic [31:0]           r_staged;
  logic [31:0]           r_shadow;
  logic                  r_pending;
  logic                  r_frame_done;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_digit_sel;

  logic                  w_tick;
  logic                  w_wrap;
  logic [CntW-1:0]       w_div_cnt_d;
  logic [IdxW-1:0]       w_idx_d;
  logic [31:0]           w_staged_d;
  logic [31:0]           w_shadow_d;
  logic                  w_pending_d;
  logic [3:0]            w_nibble;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [6:0]            w_seg_hi;

  always_comb begin
    w_tick      = (r_div_cnt == CntMax);
    w_wrap      = w_tick && (r_idx == IdxMax);
    w_div_cnt_d = w_tick ? '0 : r_div_cnt + 1'b1;
    w_idx_d     = r_idx;
    if (w_wrap) begin
      w_idx_d = '0;
    end else if (w_tick) begin
      w_idx_d = r_idx + 1'b1;
    end
    w_staged_d = data_load ? data_in : r_staged;
    // A load landing on the wrap tick bypasses staging and is shown straight away.
    w_shadow_d = r_shadow;
    if (w_wrap) begin
      if (data_load) begin
        w_shadow_d = data_in;
      end else if (r_pending) begin
        w_shadow_d = r_staged;
      end
    end
    w_pending_d = w_wrap ? 1'b0 : (data_load | r_pending);
  end

  always_comb begin
    w_nibble = '0;
    w_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IdxW'(k)) begin
        w_nibble    = r_shadow[4*k +: 4];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // Active-high segment pattern, bit order g..a.
  always_comb begin
    w_seg_hi = '0;
    case (w_nibble)
      4'h0: w_seg_hi = 7'h3F;
      4'h1: w_seg_hi = 7'h06;
      4'h2: w_seg_hi = 7'h5B;
      4'h3: w_seg_hi = 7'h4F;
      4'h4: w_seg_hi = 7'h66;
      4'h5: w_seg_hi = 7'h6D;
      4'h6: w_seg_hi = 7'h7D;
      4'h7: w_seg_hi = 7'h07;
      4'h8: w_seg_hi = 7'h7F;
      4'h9: w_seg_hi = 7'h6F;
      4'hA: w_seg_hi = 7'h77;
      4'hB: w_seg_hi = 7'h7C;
      4'hC: w_seg_hi = 7'h39;
      4'hD: w_seg_hi = 7'h5E;
      4'hE: w_seg_hi = 7'h79;
      4'hF: w_seg_hi = 7'h71;
      default: w_seg_hi = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt    <= '0;
      r_idx        <= '0;
      r_staged     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_seg        <= SegOff;
      r_digit_sel  <= DigOff;
    end else begin
      r_div_cnt    <= w_div_cnt_d;
      r_idx        <= w_idx_d;
      r_staged     <= w_staged_d;
      r_shadow     <= w_shadow_d;
      r_pending    <= w_pending_d;
      r_frame_done <= w_wrap;
      r_seg        <= w_seg_hi ^ SegOff;
      r_digit_sel  <= w_onehot ^ DigOff;
    end
  end

  assign seg            = r_seg;
  assign digit_sel      = r_digit_sel;
  assign update_pending = r_pending;
  assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a 4-digit/div-4 instance and a 1-digit/div-1 instance,
// expected outputs queued per cycle and compared at the following falling edge.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, data_load;
  logic [31:0] data_in;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        update_pending, frame_done;

  logic        rst1_n, load1;
  logic [31:0] din1;
  logic [6:0]  seg1;
  logic [0:0]  dsel1;
  logic        pend1, fd1;

  seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_load(data_load),
    .seg(seg), .digit_sel(digit_sel), .update_pending(update_pending),
    .frame_done(frame_done)
  );

  seg_scan_driver #(
    .NUM_DIGITS(1), .CLK_DIV(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .data_in(din1), .data_load(load1),
    .seg(seg1), .digit_sel(dsel1), .update_pending(pend1), .frame_done(fd1)
  );

  typedef struct {
    string      tag;
    bit         dut;
    logic [6:0] seg;
    logic [3:0] dsel;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         n = 0;
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed no entry expected one");
      return;
    end
    e = sb.pop_front();
    if (!e.dut) begin
      check($sformatf("%s n=%0d dsel", e.tag, n), {4'h0, digit_sel}, {4'h0, e.dsel});
      check($sformatf("%s n=%0d seg", e.tag, n), {1'b0, seg}, {1'b0, e.seg});
      check($sformatf("%s n=%0d pend", e.tag, n), {7'h0, update_pending}, {7'h0, e.pend});
      check($sformatf("%s n=%0d fdone", e.tag, n), {7'h0, frame_done}, {7'h0, e.fd});
    end else begin
      check($sformatf("%s dsel", e.tag), {7'h0, dsel1}, {7'h0, e.dsel[0]});
      check($sformatf("%s seg", e.tag), {1'b0, seg1}, {1'b0, e.seg});
      check($sformatf("%s pend", e.tag), {7'h0, pend1}, {7'h0, e.pend});
      check($sformatf("%s fdone", e.tag), {7'h0, fd1}, {7'h0, e.fd});
    end
  endtask

  // Output after rising edge n shows digit ((n-1)/4)%4; frames wrap every 16 edges.
  task automatic cyc0(input string tag, input logic [31:0] word, input logic pend);
    exp_t        e;
    int          d;
    logic [31:0] sh;
    n++;
    d      = ((n - 1) / 4) % 4;
    sh     = word >> (4 * d);
    e.tag  = tag;
    e.dut  = 1'b0;
    e.dsel = ~(4'b0001 << d);
    e.seg  = ~tbl[sh[3:0]];
    e.pend = pend;
    e.fd   = (n % 16 == 0);
    sb.push_back(e);
    @(posedge clk);
    #1 data_load = 1'b0;
    @(negedge clk);
    compare_next();
  endtask

  task automatic run0(input int cnt, input string tag, input logic [31:0] word,
                      input logic pend);
    repeat (cnt) cyc0(tag, word, pend);
  endtask

  task automatic load0(input logic [31:0] v);
    data_in   = v;
    data_load = 1'b1;
  endtask

  task automatic cyc1(input string tag, input logic [6:0] seg_exp);
    exp_t e;
    e.tag  = tag;
    e.dut  = 1'b1;
    e.dsel = 4'h0;
    e.seg  = seg_exp;
    e.pend = 1'b0;
    e.fd   = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 load1 = 1'b0;
    @(negedge clk);
    compare_next();
  endtask

  initial begin
    reset_n   = 1'b0;
    rst1_n    = 1'b0;
    data_load = 1'b0;
    data_in   = '0;
    load1     = 1'b0;
    din1      = '0;
    repeat (3) @(negedge clk);

    check("rst_dsel", {4'h0, digit_sel}, 8'h0F);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_pend", {7'h0, update_pending}, 8'h00);
    check("rst_fdone", {7'h0, frame_done}, 8'h00);

    // Free-running scan of zeros for two frames.
    reset_n = 1'b1;
    n = 0;
    run0(32, "t1_scan", 32'h0, 1'b0);

    // Mid-frame load held until the wrap at edge 48.
    run0(4, "t2_pre", 32'h0, 1'b0);
    load0(32'h0000_A5F1);
    run0(11, "t2_stage", 32'h0, 1'b1);
    run0(1, "t2_wrap", 32'h0, 1'b0);
    run0(16, "t2_show", 32'h0000_A5F1, 1'b0);

    // Two loads in one frame: last one wins.
    run0(2, "t3_pre", 32'h0000_A5F1, 1'b0);
    load0(32'h0000_1111);
    run0(3, "t3_stage1", 32'h0000_A5F1, 1'b1);
    load0(32'h0000_2222);
    run0(10, "t3_stage2", 32'h0000_A5F1, 1'b1);
    run0(1, "t3_wrap", 32'h0000_A5F1, 1'b0);
    run0(15, "t3_show", 32'h0000_2222, 1'b0);

    // Load landing exactly on the wrap tick (edge 96) bypasses staging.
    load0(32'h0000_8888);
    run0(1, "t4_wrap", 32'h0000_2222, 1'b0);
    run0(16, "t4_show", 32'h0000_8888, 1'b0);

    // Async reset while a word is pending.
    load0(32'h0000_1234);
    run0(3, "t6_stage", 32'h0000_8888, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t6_async_dsel", {4'h0, digit_sel}, 8'h0F);
    check("t6_async_seg", {1'b0, seg}, 8'h7F);
    check("t6_async_pend", {7'h0, update_pending}, 8'h00);
    check("t6_async_fdone", {7'h0, frame_done}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("t6_held_pend", {7'h0, update_pending}, 8'h00);
    reset_n = 1'b1;
    n = 0;
    run0(32, "t6_after", 32'h0, 1'b0);

    // Single digit, divide-by-one: every cycle is a frame wrap.
    rst1_n = 1'b1;
    repeat (3) cyc1("t5_idle", 7'h40);
    din1  = 32'hFFFF_FFF7;
    load1 = 1'b1;
    cyc1("t5_load_edge", 7'h40);
    cyc1("t5_show", 7'h78);
    cyc1("t5_hold", 7'h78);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
